// File: rtl/reg_read_stage.sv
// Register-read stage: operand fetch with write-back bypass,
// per-register busy scoreboard and a registered handoff slot to execute.
module reg_read_stage #(
   parameter int XLEN = 32,
   parameter int FLEN = 64,
   parameter int RAW  = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_pc,
   input  logic [31:0]     in_insn,
   input  logic [RAW-1:0]  in_src1_addr,
   input  logic [RAW-1:0]  in_src2_addr,
   input  logic            in_src1_fp,
   input  logic            in_src2_fp,
   input  logic            in_src1_en,
   input  logic            in_src2_en,
   input  logic [RAW-1:0]  in_dst_addr,
   input  logic            in_int_wen,
   input  logic            in_fp_wen,
   output logic [RAW-1:0]  int_rd_addr1,
   output logic [RAW-1:0]  int_rd_addr2,
   input  logic [XLEN-1:0] int_rd_data1,
   input  logic [XLEN-1:0] int_rd_data2,
   output logic [RAW-1:0]  fp_rd_addr1,
   output logic [RAW-1:0]  fp_rd_addr2,
   input  logic [FLEN-1:0] fp_rd_data1,
   input  logic [FLEN-1:0] fp_rd_data2,
   input  logic            wb_int_wen,
   input  logic [RAW-1:0]  wb_int_addr,
   input  logic [XLEN-1:0] wb_int_data,
   input  logic            wb_fp_wen,
   input  logic [RAW-1:0]  wb_fp_addr,
   input  logic [FLEN-1:0] wb_fp_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [31:0]     out_pc,
   output logic [31:0]     out_insn,
   output logic [XLEN-1:0] out_src1_int,
   output logic [XLEN-1:0] out_src2_int,
   output logic [FLEN-1:0] out_src1_fp,
   output logic [FLEN-1:0] out_src2_fp,
   output logic [RAW-1:0]  out_dst_addr,
   output logic            out_int_wen,
   output logic            out_fp_wen
);

   localparam int NR = 1 << RAW;

   logic [NR-1:0]   int_busy_q, int_busy_d;
   logic [NR-1:0]   fp_busy_q, fp_busy_d;
   logic            valid_q;
   logic [31:0]     pc_q, insn_q;
   logic [XLEN-1:0] s1i_q, s2i_q, s1i_d, s2i_d;
   logic [FLEN-1:0] s1f_q, s2f_q, s1f_d, s2f_d;
   logic [RAW-1:0]  dst_q;
   logic            iwen_q, fwen_q;

   logic wbi_ok;
   logic s1_wbi, s2_wbi, s1_wbf, s2_wbf, d_wbi, d_wbf;
   logic h1, h2, hd, hazard, slot_free, accept;

   assign int_rd_addr1 = in_src1_addr;
   assign int_rd_addr2 = in_src2_addr;
   assign fp_rd_addr1  = in_src1_addr;
   assign fp_rd_addr2  = in_src2_addr;

   // x0 is hardwired, so a write-back to it neither bypasses nor clears
   assign wbi_ok = wb_int_wen && (wb_int_addr != '0);
   assign s1_wbi = wbi_ok && (wb_int_addr == in_src1_addr);
   assign s2_wbi = wbi_ok && (wb_int_addr == in_src2_addr);
   assign d_wbi  = wbi_ok && (wb_int_addr == in_dst_addr);
   assign s1_wbf = wb_fp_wen && (wb_fp_addr == in_src1_addr);
   assign s2_wbf = wb_fp_wen && (wb_fp_addr == in_src2_addr);
   assign d_wbf  = wb_fp_wen && (wb_fp_addr == in_dst_addr);

   assign h1 = in_src1_en && (in_src1_fp
             ? (fp_busy_q[in_src1_addr] && !s1_wbf)
             : ((in_src1_addr != '0) && int_busy_q[in_src1_addr] && !s1_wbi));
   assign h2 = in_src2_en && (in_src2_fp
             ? (fp_busy_q[in_src2_addr] && !s2_wbf)
             : ((in_src2_addr != '0) && int_busy_q[in_src2_addr] && !s2_wbi));
   assign hd = (in_int_wen && (in_dst_addr != '0) && int_busy_q[in_dst_addr] && !d_wbi)
            || (in_fp_wen && fp_busy_q[in_dst_addr] && !d_wbf);
   assign hazard = h1 || h2 || hd;

   assign slot_free = !valid_q || out_ready;
   assign in_ready  = slot_free && !hazard && !flush && !rst;
   assign accept    = in_valid && in_ready;

   always_comb begin
      s1i_d = '0;
      s2i_d = '0;
      s1f_d = '0;
      s2f_d = '0;
      if (in_src1_en && !in_src1_fp && (in_src1_addr != '0))
         s1i_d = s1_wbi ? wb_int_data : int_rd_data1;
      if (in_src2_en && !in_src2_fp && (in_src2_addr != '0))
         s2i_d = s2_wbi ? wb_int_data : int_rd_data2;
      if (in_src1_en && in_src1_fp)
         s1f_d = s1_wbf ? wb_fp_data : fp_rd_data1;
      if (in_src2_en && in_src2_fp)
         s2f_d = s2_wbf ? wb_fp_data : fp_rd_data2;
   end

   // clear first so a same-cycle set on the same register wins
   always_comb begin
      int_busy_d = int_busy_q;
      fp_busy_d  = fp_busy_q;
      if (flush) begin
         int_busy_d = '0;
         fp_busy_d  = '0;
      end else begin
         if (wbi_ok) int_busy_d[wb_int_addr] = 1'b0;
         if (wb_fp_wen) fp_busy_d[wb_fp_addr] = 1'b0;
         if (accept && in_int_wen && (in_dst_addr != '0))
            int_busy_d[in_dst_addr] = 1'b1;
         if (accept && in_fp_wen)
            fp_busy_d[in_dst_addr] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q    <= 1'b0;
         pc_q       <= '0;
         insn_q     <= '0;
         s1i_q      <= '0;
         s2i_q      <= '0;
         s1f_q      <= '0;
         s2f_q      <= '0;
         dst_q      <= '0;
         iwen_q     <= 1'b0;
         fwen_q     <= 1'b0;
         int_busy_q <= '0;
         fp_busy_q  <= '0;
      end else begin
         int_busy_q <= int_busy_d;
         fp_busy_q  <= fp_busy_d;
         if (flush) begin
            valid_q <= 1'b0;
         end else if (accept) begin
            valid_q <= 1'b1;
            pc_q    <= in_pc;
            insn_q  <= in_insn;
            s1i_q   <= s1i_d;
            s2i_q   <= s2i_d;
            s1f_q   <= s1f_d;
            s2f_q   <= s2f_d;
            dst_q   <= in_dst_addr;
            iwen_q  <= in_int_wen;
            fwen_q  <= in_fp_wen;
         end else if (out_ready) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign out_valid    = valid_q;
   assign out_pc       = pc_q;
   assign out_insn     = insn_q;
   assign out_src1_int = s1i_q;
   assign out_src2_int = s2i_q;
   assign out_src1_fp  = s1f_q;
   assign out_src2_fp  = s2f_q;
   assign out_dst_addr = dst_q;
   assign out_int_wen  = iwen_q;
   assign out_fp_wen   = fwen_q;

   a_one_wen: assert property (@(posedge clk) disable iff (rst)
      !(in_valid && in_int_wen && in_fp_wen));

endmodule
